// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one registered AND/OR/XOR/NOR unit between two requesters
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d, owner_q, owner_d, zero_q, zero_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res;
  logic             grant, accept, take;
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    accept     = !rst && state_q == IDLE && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    res        = op_q == 2'b00 ? (a_q & b_q) :
                 op_q == 2'b01 ? (a_q | b_q) :
                 op_q == 2'b10 ? (a_q ^ b_q) : ~(a_q | b_q);
    take       = state_q == RESP && (owner_q ? rsp1_ready : rsp0_ready);
    state_d    = accept ? EXEC : state_q == EXEC ? RESP : take ? IDLE : state_q;
    last_d     = accept ? grant : last_q;
    owner_d    = accept ? grant : owner_q;
    op_d       = accept ? (grant ? req1_op : req0_op) : op_q;
    a_d        = accept ? (grant ? req1_a : req0_a) : a_q;
    b_d        = accept ? (grant ? req1_b : req0_b) : b_q;
    res_d      = state_q == EXEC ? res : res_q;
    zero_d     = state_q == EXEC ? res == '0 : zero_q;
    rsp0_valid = state_q == RESP && !owner_q;
    rsp1_valid = state_q == RESP && owner_q;
    rsp0_data  = rsp0_valid ? res_q : '0;
    rsp1_data  = rsp1_valid ? res_q : '0;
    rsp0_zero  = rsp0_valid && zero_q;
    rsp1_zero  = rsp1_valid && zero_q;
    busy       = state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed plus random stimulus against a transaction-level reference model
module tb_logic_unit_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        v0 = 0, v1 = 0, r0 = 0, r1 = 0;
  logic [1:0]  op0 = 0, op1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy;
  logic [31:0] rsp0_data, rsp1_data;
  int          n_vec = 0, n_err = 0, cyc = 0;
  bit          have = 0, own = 0, last = 1;
  int          acc = 0;
  logic [31:0] exp_res = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .rsp0_valid(rsp0_valid), .rsp0_ready(r0), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .rsp1_valid(rsp1_valid), .rsp1_ready(r1), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
    .busy(busy)
  );

  function automatic logic [31:0] lu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model by what the rising edge commits.
  task automatic tick();
    bit g, rdy, ev0, ev1;
    @(negedge clk);
    #1;
    g   = (v0 && v1) ? !last : v1;
    rdy = !rst && !have && (v0 || v1);
    ev0 = have && !own && cyc >= acc + 2;
    ev1 = have && own && cyc >= acc + 2;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, rdy && !g});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, rdy && g});
    chk("busy", {31'b0, busy}, {31'b0, have});
    chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, ev0});
    chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, ev1});
    chk("rsp0_data", rsp0_data, ev0 ? exp_res : 32'h0);
    chk("rsp1_data", rsp1_data, ev1 ? exp_res : 32'h0);
    chk("rsp0_zero", {31'b0, rsp0_zero}, {31'b0, ev0 && exp_res == 0});
    chk("rsp1_zero", {31'b0, rsp1_zero}, {31'b0, ev1 && exp_res == 0});
    if (rst) begin
      have = 0;
      last = 1;
    end else if (rdy) begin
      have    = 1;
      acc     = cyc;
      own     = g;
      last    = g;
      exp_res = g ? lu(op1, a1, b1) : lu(op0, a0, b0);
    end else if ((ev0 && r0) || (ev1 && r1)) have = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    @(posedge clk);
    #1;
    tick(); tick();
    rst = 0;
    tick(); tick();
    v0 = 1; op0 = 2'd0; a0 = 32'hFFFF_0000; b0 = 32'h0F0F_0F0F; r0 = 1;
    tick();
    v0 = 0;
    repeat (3) tick();
    v0 = 1; op0 = 2'd2; a0 = 32'hAAAA_AAAA; b0 = 32'h5555_5555;
    v1 = 1; op1 = 2'd1; a1 = 32'h0; b1 = 32'h1; r1 = 1;
    repeat (12) tick();
    v0 = 0;
    repeat (4) tick();
    v1 = 0;
    repeat (3) tick();
    v1 = 1; op1 = 2'd3; a1 = 32'hFFFF_FFFF; b1 = 32'h0; r1 = 0;
    tick();
    v1 = 0; v0 = 1; op0 = 2'd1; a0 = 32'h1234_0000; b0 = 32'h0000_5678;
    repeat (7) tick();
    r1 = 1;
    tick();
    r1 = 0;
    repeat (4) tick();
    v0 = 0;
    tick();
    v0 = 1; op0 = 2'd0; a0 = 32'hFFFF_FFFF; b0 = 32'h1234_5678; r0 = 0;
    tick();
    v0 = 0; a0 = 32'h0;
    repeat (4) tick();
    r0 = 1;
    repeat (2) tick();
    r0 = 0; v0 = 1; op0 = 2'd2; a0 = 32'h0F0F_0F0F; b0 = 32'h1;
    tick();
    v0 = 0; rst = 1;
    tick();
    rst = 0;
    repeat (3) tick();
    v1 = 1; op1 = 2'd3; a1 = 32'h1; b1 = 32'h2;
    tick();
    v1 = 0;
    repeat (2) tick();
    rst = 1; v0 = 1;
    tick();
    rst = 0; v1 = 1; r0 = 1; r1 = 1;
    repeat (6) tick();
    v0 = 0; v1 = 0;
    tick();
    repeat (2000) begin
      rst = $urandom_range(0, 40) == 0;
      v0  = $urandom_range(0, 9) < 6;
      v1  = $urandom_range(0, 9) < 6;
      r0  = $urandom_range(0, 1);
      r1  = $urandom_range(0, 1);
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      a0  = rnd_operand(); b0 = rnd_operand();
      a1  = rnd_operand(); b1 = rnd_operand();
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
